// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// sequencing each access over MEM_LAT cycles with fair round-robin on ties.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [1:0]        dm_size,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [15:0]       contend
);

    localparam int unsigned      CNT_W       = 3;
    localparam logic [CNT_W-1:0] LAT         = CNT_W'(MEM_LAT);
    localparam logic [1:0]       SZ_WORD     = 2'b00;
    localparam logic [15:0]      CONTEND_MAX = 16'hFFFF;
    localparam logic             LAST_IF     = 1'b0;
    localparam logic             LAST_DM     = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               rw_q, rw_d;
    logic               grant_if, grant_dm;
    logic               if_ready_d, dm_ready_d;
    logic [DATA_W-1:0]  if_rdata_d, dm_rdata_d;
    logic               mem_en_d, mem_rw_d;
    logic [15:0]        contend_d;

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign mem_size = size_q;

    // Next-state, grant and completion decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        rw_d       = rw_q;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;

        case (state_q)
            IDLE: begin
                if (if_req && dm_req) begin
                    grant_if = (last_q == LAST_DM);
                    grant_dm = (last_q == LAST_IF);
                end else begin
                    grant_if = if_req;
                    grant_dm = dm_req;
                end
            end
            BUSY_I: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if_rdata_d = mem_dout;
                    if_ready_d = 1'b1;
                    last_d     = LAST_IF;
                    state_d    = IDLE;
                    grant_dm   = dm_req;
                end
            end
            BUSY_D: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (rw_q) begin
                        dm_rdata_d = mem_dout;
                    end
                    dm_ready_d = 1'b1;
                    last_d     = LAST_DM;
                    state_d    = IDLE;
                    grant_if   = if_req;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant latches the winner's request so the memory sees a stable access
        if (grant_if) begin
            state_d = BUSY_I;
            cnt_d   = LAT;
            addr_d  = if_addr;
            size_d  = SZ_WORD;
            rw_d    = 1'b1;
        end
        if (grant_dm) begin
            state_d = BUSY_D;
            cnt_d   = LAT;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            size_d  = dm_size;
            rw_d    = dm_rw;
        end

        mem_en_d = (state_d != IDLE);
        mem_rw_d = (state_d != IDLE) ? rw_d : 1'b1;

        contend_d = contend;
        if (if_req && dm_req && (contend != CONTEND_MAX)) begin
            contend_d = contend + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= LAST_IF;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_WORD;
            rw_q     <= 1'b1;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
            mem_en   <= 1'b0;
            mem_rw   <= 1'b1;
            contend  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            rw_q     <= rw_d;
            if_ready <= if_ready_d;
            dm_ready <= dm_ready_d;
            if_rdata <= if_rdata_d;
            dm_rdata <= dm_rdata_d;
            mem_en   <= mem_en_d;
            mem_rw   <= mem_rw_d;
            contend  <= contend_d;
        end
    end

endmodule
